aes_word_stream_if: RTL and testbench

- 32-bit streaming front/back end for the AES-128 core.
- Upstream, it packs key and data words into 128-bit registers and issues one start pulse per block. It holds the core inputs stable until the core's one-cycle ready pulse.
- Downstream, it captures the core result and serialises it as four 32-bit words with valid/ready.
- Lets a bus-width host drive the core without holding 128-bit buses.

---
 rtl/aes_word_stream_if.sv | 176 +++++++++++++++++
 tb/tb_aes_word_stream_if.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_word_stream_if.sv
// -----------------------------------------------------------------------------
// aes_word_stream_if
//   32-bit streaming front/back end for an AES-128 core. Key and data words are
//   packed into 128-bit registers (first word = bits [127:96]). Each completed
//   data group issues one core_start pulse. Key, text and direction are held
//   stable until the core's ready pulse. The result is then serialised as four
//   32-bit words with valid/ready, MS word first.
//
//   Optional feature: define AES_CBC_EN to enable CBC chaining. s_sel=2 words
//   then load the IV. Without it, s_sel=2 words are accepted and dropped (ECB).
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   s_valid/s_ready/s_sel/s_data   input word stream (sel 0=key 1=data 2=IV)
//   cfg_decrypt             direction, sampled with the 4th data word
//   m_valid/m_ready/m_data  output word stream
//   busy, err_timeout       status (err_timeout sticky until next key word)
//   core_start, core_en_or_de, core_key, core_text   to AES core
//   core_result, core_result_ready                   from AES core
// -----------------------------------------------------------------------------
module aes_word_stream_if #(
  parameter int unsigned TIMEOUT_CYCLES = 1023,
  parameter int unsigned CNT_W          = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [1:0]   s_sel,
  input  logic [31:0]  s_data,
  input  logic         cfg_decrypt,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [31:0]  m_data,
  output logic         busy,
  output logic         err_timeout,
  output logic         core_start,
  output logic         core_en_or_de,
  output logic [127:0] core_key,
  output logic [127:0] core_text,
  input  logic [127:0] core_result,
  input  logic         core_result_ready
);

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_START   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_OUT     = 2'd3
  } state_t;

  state_t             state_q;
  logic [127:0]       key_q;
  logic [1:0]         key_cnt_q;
  logic               key_valid_q;
  logic [127:0]       text_q;
  logic [1:0]         data_cnt_q;
  logic               en_q;
  logic [127:0]       out_buf_q;
  logic [1:0]         out_cnt_q;
  logic [CNT_W-1:0]   tmo_q;
  logic [CNT_W-1:0]   tmo_d;
  logic               err_q;
  logic               s_fire;
  logic               tmo_expire;
  logic [127:0]       result_d;

`ifdef AES_CBC_EN
  logic [127:0]       chain_q;
`endif

  // Data words wait for a complete key; all other word types are always taken.
  assign s_ready    = (state_q == ST_COLLECT) && ((s_sel != 2'd1) || key_valid_q);
  assign s_fire     = s_valid && s_ready;

  assign m_valid    = (state_q == ST_OUT);
  assign m_data     = m_valid ? out_buf_q[127:96] : 32'h0;
  assign busy       = (state_q != ST_COLLECT);
  assign core_start = (state_q == ST_START);
  assign err_timeout   = err_q;
  assign core_en_or_de = en_q;
  assign core_key      = key_q;

  // The counter is cleared in START, so WAIT lasts at most TIMEOUT_CYCLES cycles.
  assign tmo_d      = tmo_q + CNT_W'(1);
  assign tmo_expire = (tmo_d == CNT_W'(TIMEOUT_CYCLES));

`ifdef AES_CBC_EN
  // Encrypt whitens the plaintext with the chain; decrypt unwhitens the result.
  assign core_text = en_q ? (text_q ^ chain_q) : text_q;
  assign result_d  = en_q ? core_result : (core_result ^ chain_q);
`else
  assign core_text = text_q;
  assign result_d  = core_result;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_COLLECT;
      key_q       <= '0;
      key_cnt_q   <= '0;
      key_valid_q <= 1'b0;
      text_q      <= '0;
      data_cnt_q  <= '0;
      en_q        <= 1'b1;
      out_buf_q   <= '0;
      out_cnt_q   <= '0;
      tmo_q       <= '0;
      err_q       <= 1'b0;
`ifdef AES_CBC_EN
      chain_q     <= '0;
`endif
    end else begin
      case (state_q)
        ST_COLLECT: begin
          if (s_fire) begin
            case (s_sel)
              2'd0: begin
                key_q     <= {key_q[95:0], s_data};
                key_cnt_q <= key_cnt_q + 2'd1;
                err_q     <= 1'b0;
                // A new key group invalidates the key until all four words land.
                if (key_cnt_q == 2'd0) key_valid_q <= 1'b0;
                if (key_cnt_q == 2'd3) key_valid_q <= 1'b1;
              end
              2'd1: begin
                text_q     <= {text_q[95:0], s_data};
                data_cnt_q <= data_cnt_q + 2'd1;
                if (data_cnt_q == 2'd3) begin
                  en_q    <= ~cfg_decrypt;
                  state_q <= ST_START;
                end
              end
              2'd2: begin
`ifdef AES_CBC_EN
                chain_q <= {chain_q[95:0], s_data};
`endif
              end
              default: begin
              end
            endcase
          end
        end
        ST_START: begin
          tmo_q   <= '0;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          // A ready pulse wins over a simultaneous timeout expiry.
          if (core_result_ready) begin
            out_buf_q <= result_d;
            out_cnt_q <= '0;
`ifdef AES_CBC_EN
            chain_q   <= en_q ? core_result : text_q;
`endif
            state_q   <= ST_OUT;
          end else if (tmo_expire) begin
            err_q   <= 1'b1;
            state_q <= ST_COLLECT;
          end else begin
            tmo_q <= tmo_d;
          end
        end
        ST_OUT: begin
          if (m_ready) begin
            out_buf_q <= {out_buf_q[95:0], 32'h0};
            out_cnt_q <= out_cnt_q + 2'd1;
            if (out_cnt_q == 2'd3) state_q <= ST_COLLECT;
          end
        end
        default: state_q <= ST_COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_word_stream_if.sv
// -----------------------------------------------------------------------------
// tb_aes_word_stream_if
//   Scoreboard bench. A behavioural core stands in for the AES core (FIPS-197
//   pair plus an invertible mixing function). The reference model works on
//   whole word groups and pushes expected output words when a block is issued;
//   a monitor pops and compares whenever an output word is handshaken.
// -----------------------------------------------------------------------------
module tb_aes_word_stream_if;

  localparam int TMO = 20;
  localparam logic [127:0] FK   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FP   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FC   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] MIXC = 128'hc3a5_5a3c_0f1e_2d4b_9687_7869_e1d2_b4f0;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         s_valid, s_ready;
  logic [1:0]   s_sel;
  logic [31:0]  s_data;
  logic         cfg_decrypt;
  logic         m_valid, m_ready;
  logic [31:0]  m_data;
  logic         busy, err_timeout, core_start, core_en_or_de;
  logic [127:0] core_key, core_text, core_result;
  logic         core_result_ready;

  always #5 clk = ~clk;

  aes_word_stream_if #(.TIMEOUT_CYCLES(TMO), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_sel(s_sel), .s_data(s_data),
    .cfg_decrypt(cfg_decrypt),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .busy(busy), .err_timeout(err_timeout),
    .core_start(core_start), .core_en_or_de(core_en_or_de),
    .core_key(core_key), .core_text(core_text),
    .core_result(core_result), .core_result_ready(core_result_ready)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_start = 0;
  int hs_cnt  = 0;
  bit core_en = 1'b1;
  logic [31:0] exp_q[$];
  logic [31:0] rx_q[$];
  bit          pat_q[$];

  // reference model state
  logic [31:0]  m_key_w[4];
  int           m_key_cnt;
  bit           m_key_valid;
  logic [31:0]  m_dat_w[4];
  int           m_dat_cnt;
  logic [127:0] m_chain;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] core_fn(input logic [127:0] k, input logic [127:0] t,
                                           input logic enc);
    logic [127:0] x;
    if (k == FK && enc && t == FP) return FC;
    if (k == FK && !enc && t == FC) return FP;
    if (enc) begin
      x = {t[114:0], t[127:115]};
      return x ^ k ^ MIXC;
    end
    x = t ^ k ^ MIXC;
    return {x[12:0], x[127:13]};
  endfunction

  function automatic logic [127:0] rx_at(input int idx);
    return {rx_q[idx], rx_q[idx+1], rx_q[idx+2], rx_q[idx+3]};
  endfunction

  task automatic model_reset();
    m_key_cnt = 0; m_key_valid = 0; m_dat_cnt = 0; m_chain = '0;
    for (int i = 0; i < 4; i++) begin m_key_w[i] = '0; m_dat_w[i] = '0; end
  endtask

  task automatic model_accept(input logic [1:0] sel, input logic [31:0] d, input logic dec);
    logic [127:0] k, t, o;
    o = '0;
    case (sel)
      2'd0: begin
        if (m_key_cnt == 0) m_key_valid = 0;
        m_key_w[m_key_cnt] = d;
        if (m_key_cnt == 3) m_key_valid = 1;
        m_key_cnt = (m_key_cnt + 1) % 4;
      end
      2'd1: begin
        m_dat_w[m_dat_cnt] = d;
        m_dat_cnt++;
        if (m_dat_cnt == 4) begin
          m_dat_cnt = 0;
          k = {m_key_w[0], m_key_w[1], m_key_w[2], m_key_w[3]};
          t = {m_dat_w[0], m_dat_w[1], m_dat_w[2], m_dat_w[3]};
`ifdef AES_CBC_EN
          if (!dec) begin
            o = core_fn(k, t ^ m_chain, 1'b1);
            if (core_en) m_chain = o;
          end else begin
            o = core_fn(k, t, 1'b0) ^ m_chain;
            if (core_en) m_chain = t;
          end
`else
          o = core_fn(k, t, !dec);
`endif
          if (core_en)
            for (int i = 0; i < 4; i++) exp_q.push_back(o[127-32*i -: 32]);
          check("start_latency", core_start, 1);
        end
      end
      2'd2: begin
`ifdef AES_CBC_EN
        m_chain = {m_chain[95:0], d};
`endif
      end
      default: begin
      end
    endcase
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send_word(input logic [1:0] sel, input logic [31:0] d, input logic dec);
    int budget = 300;
    bit ok = 0;
    s_valid = 1'b1; s_sel = sel; s_data = d; cfg_decrypt = dec;
    while (budget > 0) begin
      @(negedge clk);
      if (s_ready) begin ok = 1; break; end
      budget--;
    end
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL s_ready_wait: sel %0d never accepted", sel);
      s_valid = 1'b0;
      @(posedge clk); #1;
      return;
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    model_accept(sel, d, dec);
  endtask

  task automatic send_key(input logic [127:0] k);
    for (int i = 0; i < 4; i++) send_word(2'd0, k[127-32*i -: 32], 1'b0);
  endtask

  task automatic send_data(input logic [127:0] t, input logic dec);
    for (int i = 0; i < 4; i++) send_word(2'd1, t[127-32*i -: 32], dec);
  endtask

  task automatic send_iv(input logic [127:0] v);
    for (int i = 0; i < 4; i++) send_word(2'd2, v[127-32*i -: 32], 1'b0);
  endtask

  task automatic wait_idle();
    int b = 0;
    while ((exp_q.size() != 0 || busy) && b < 500) begin @(negedge clk); b++; end
    n_tests++;
    if (b >= 500) begin
      n_fail++;
      $display("FAIL drain: %0d words outstanding busy=%0d", exp_q.size(), busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic reset_checks();
    s_sel = 2'd1; #1;
    check("rst_s_ready_data", s_ready, 0);
    s_sel = 2'd0; #1;
    check("rst_s_ready_key", s_ready, 1);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err_timeout, 0);
    check("rst_core_start", core_start, 0);
    check("rst_en_or_de", core_en_or_de, 1);
    check("rst_core_key", core_key, 0);
    check("rst_core_text", core_text, 0);
  endtask

  // Behavioural AES core: random latency, stability checks, timeout timing.
  initial begin : core_model
    bit busy_c = 0, pulsed = 0;
    int lat = 0, tcnt = 0;
    logic [127:0] ck, ct;
    logic ce;
    ck = '0; ct = '0; ce = 1'b0;
    core_result_ready = 1'b0;
    core_result = '0;
    forever begin
      @(posedge clk); #1;
      core_result_ready = 1'b0;
      if (pulsed) begin
        check("m_valid_after_ready", m_valid, 1);
        pulsed = 0;
      end
      if (!reset_n) begin busy_c = 0; continue; end
      if (!busy_c) begin
        if (core_start) begin
          busy_c = 1; ck = core_key; ct = core_text; ce = core_en_or_de;
          lat = $urandom_range(0, 6); tcnt = 0; n_start++;
        end else if ($urandom_range(0, 15) == 0) begin
          core_result_ready = 1'b1;
          core_result = {$urandom, $urandom, $urandom, $urandom};
        end
      end else begin
        tcnt++;
        if (core_start) begin
          n_tests++; n_fail++;
          $display("FAIL double_start: core_start while block outstanding");
        end
        if (tcnt <= TMO) begin
          check("wait_key_stable", core_key, ck);
          check("wait_text_stable", core_text, ct);
          check("wait_dir_stable", core_en_or_de, ce);
        end
        if (core_en) begin
          if (lat == 0) begin
            core_result = core_fn(ck, ct, ce);
            core_result_ready = 1'b1;
            busy_c = 0; pulsed = 1;
          end else lat--;
        end else begin
          if (tcnt == TMO) begin
            check("tmo_err_early", err_timeout, 0);
            check("tmo_busy_early", busy, 1);
          end
          if (tcnt == TMO + 1) begin
            check("tmo_err_set", err_timeout, 1);
            check("tmo_busy_clear", busy, 0);
            busy_c = 0;
          end
        end
      end
    end
  end

  initial begin : ready_driver
    m_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (m_valid && pat_q.size() > 0) m_ready = pat_q.pop_front();
      else m_ready = ($urandom_range(0, 2) != 0);
    end
  end

  initial begin : monitor
    bit stalled = 0;
    logic [31:0] held = '0;
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (reset_n && m_valid) begin
        check("s_ready_in_out", s_ready, 0);
        if (stalled) check("m_data_hold", m_data, held);
        if (m_ready) begin
          if (exp_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_word: got %h with nothing expected", m_data);
          end else begin
            e = exp_q.pop_front();
            check("m_data", m_data, e);
          end
          rx_q.push_back(m_data);
          hs_cnt++;
          stalled = 0;
        end else begin
          stalled = 1; held = m_data;
        end
      end else stalled = 0;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int base, s0, h0;
    logic [127:0] k, p, c1, c2;
    s_valid = 1'b0; s_sel = 2'd0; s_data = '0; cfg_decrypt = 1'b0;
    reset_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #3;
    reset_checks();
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;

    // FIPS-197 encrypt then decrypt (zero IV keeps CBC builds on the plain vector)
    send_key(FK);
    base = rx_q.size();
    send_data(FP, 1'b0);
    wait_idle();
    check("fips_encrypt", rx_at(base), FC);
    send_iv(128'h0);
    base = rx_q.size();
    send_data(FC, 1'b1);
    wait_idle();
    check("fips_decrypt", rx_at(base), FP);

    // Reset in the middle of partial key/data groups
    send_key({$urandom, $urandom, $urandom, $urandom});
    send_word(2'd1, $urandom, 1'b0);
    send_word(2'd1, $urandom, 1'b0);
    #2 reset_n = 1'b0;
    reset_checks();
    model_reset();
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;

    // Data before key: held off, no start
    s0 = n_start;
    p = {$urandom, $urandom, $urandom, $urandom};
    s_valid = 1'b1; s_sel = 2'd1; s_data = p[127:96];
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("nokey_s_ready", s_ready, 0);
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    check("nokey_no_start", n_start, s0);
    send_key({$urandom, $urandom, $urandom, $urandom});
    send_data(p, 1'b0);
    wait_idle();

    // Backpressure pattern on the output stream
    pat_q = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    h0 = hs_cnt;
    send_data({$urandom, $urandom, $urandom, $urandom}, 1'b1);
    wait_idle();
    check("bp_handshakes", hs_cnt - h0, 4);

    // Randomised blocks with key reloads, mid-group key words and junk words
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 3) == 0) send_key({$urandom, $urandom, $urandom, $urandom});
      for (int w = 0; w < 4; w++) begin
        if (w > 0 && $urandom_range(0, 5) == 0)
          send_key({$urandom, $urandom, $urandom, $urandom});
        if ($urandom_range(0, 4) == 0)
          send_word(2'($urandom_range(2, 3)), $urandom, 1'b0);
        send_word(2'd1, $urandom, 1'($urandom_range(0, 1)));
      end
      wait_idle();
    end

    // Timeout with a silent core; key stays valid, next key word clears error
    core_en = 1'b0;
    send_data({$urandom, $urandom, $urandom, $urandom}, 1'b0);
    wait_idle();
    core_en = 1'b1;
    check("tmo_err_sticky", err_timeout, 1);
    send_data({$urandom, $urandom, $urandom, $urandom}, 1'b0);
    wait_idle();
    check("tmo_err_kept", err_timeout, 1);
    k = {$urandom, $urandom, $urandom, $urandom};
    send_word(2'd0, k[127:96], 1'b0);
    check("tmo_err_cleared", err_timeout, 0);
    send_word(2'd0, k[95:64], 1'b0);
    send_word(2'd0, k[63:32], 1'b0);
    send_word(2'd0, k[31:0], 1'b0);
    send_data({$urandom, $urandom, $urandom, $urandom}, 1'b1);
    wait_idle();

`ifdef AES_CBC_EN
    // CBC: identical plaintexts give different ciphertexts and round-trip
    p = {$urandom, $urandom, $urandom, $urandom};
    send_iv(FK);
    base = rx_q.size();
    send_data(p, 1'b0);
    send_data(p, 1'b0);
    wait_idle();
    c1 = rx_at(base);
    c2 = rx_at(base + 4);
    n_tests++;
    if (c1 == c2) begin
      n_fail++;
      $display("FAIL cbc_ct_differ: got %h for both blocks expected different", c1);
    end
    send_iv(FK);
    base = rx_q.size();
    send_data(c1, 1'b1);
    send_data(c2, 1'b1);
    wait_idle();
    check("cbc_dec_blk0", rx_at(base), p);
    check("cbc_dec_blk1", rx_at(base + 4), p);
`else
    c1 = '0; c2 = '0;
`endif

    repeat (4) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
